// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the memory stage: load/store opcodes,
// the access-type encoding and small decode helpers.
package mips_pkg;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    // Width and signedness of a memory access; stores only use the signed forms.
    typedef enum logic [2:0] {
        ACC_NONE   = 3'd0,
        ACC_WORD   = 3'd1,
        ACC_HALF   = 3'd2,
        ACC_HALF_U = 3'd3,
        ACC_BYTE   = 3'd4,
        ACC_BYTE_U = 3'd5
    } acc_t;

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic acc_t acc_of(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:  return ACC_WORD;
            OP_LH, OP_SH:  return ACC_HALF;
            OP_LHU:        return ACC_HALF_U;
            OP_LB, OP_SB:  return ACC_BYTE;
            OP_LBU:        return ACC_BYTE_U;
            default:       return ACC_NONE;
        endcase
    endfunction

    // Words need a 4-byte boundary, halfwords a 2-byte boundary, bytes any.
    function automatic logic is_aligned(input acc_t acc, input logic [1:0] off);
        case (acc)
            ACC_WORD:            return off == 2'b00;
            ACC_HALF, ACC_HALF_U: return off[0] == 1'b0;
            default:             return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load data selection: picks the addressed byte/halfword out of the raw
// memory word (little-endian lanes) and sign- or zero-extends it.
// ACC_NONE yields zero, which is how non-loads and misaligned loads are muted.
module dm_load_ext
    import mips_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  acc_i,
    output logic [31:0] rdata_o
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Lane selection by byte offset, then extension by access type.
    always_comb begin
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        case (acc_i)
            ACC_WORD:   rdata_o = word_i;
            ACC_HALF:   rdata_o = {{16{half_sel[15]}}, half_sel};
            ACC_HALF_U: rdata_o = {16'h0000, half_sel};
            ACC_BYTE:   rdata_o = {{24{byte_sel[7]}}, byte_sel};
            ACC_BYTE_U: rdata_o = {24'h000000, byte_sel};
            default:    rdata_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/m_stage_dm.sv
// Memory-stage data memory of the 5-stage MIPS pipeline.
// Stores commit at the clock edge with a byte-lane mask; loads are read
// combinationally and extended for the M/W register. Misaligned accesses
// raise align_err, write nothing and return zero.
// Optional macro DM_WRITE_LOG_EN: prints every committed write in simulation.
module m_stage_dm
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,   // power of two
    parameter int IDX_W       = 10      // log2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_m,
    input  logic [31:0] addr_m,
    input  logic [31:0] wdata_m,
    input  logic [31:0] pc8_m,
    output logic [31:0] rdata_w,
    output logic        align_err
);

    logic [31:0]      mem_q [DEPTH_WORDS];

    logic [5:0]       opcode;
    acc_t             acc;
    logic             st;
    logic             ld;
    logic             aligned;
    logic             wr_en;
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic [31:0]      raw_word;
    logic [3:0]       lane_we;
    logic [31:0]      wdata_rep;
    logic [31:0]      wr_word_d;
    logic [2:0]       load_acc;

    assign opcode   = instr_m[31:26];
    assign acc      = acc_of(opcode);
    assign st       = is_store(opcode);
    assign ld       = is_load(opcode);
    assign idx      = addr_m[IDX_W+1:2];
    assign off      = addr_m[1:0];
    assign aligned  = is_aligned(acc, off);
    assign wr_en    = st && aligned;
    assign raw_word = mem_q[idx];

    assign align_err = (st || ld) && !aligned;

    // Byte-lane enables and lane-replicated store data for the addressed word.
    always_comb begin
        lane_we   = 4'b0000;
        wdata_rep = wdata_m;
        case (acc)
            ACC_WORD: begin
                lane_we   = 4'b1111;
                wdata_rep = wdata_m;
            end
            ACC_HALF: begin
                lane_we   = off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_m[15:0]}};
            end
            ACC_BYTE: begin
                lane_we   = 4'b0001 << off;
                wdata_rep = {4{wdata_m[7:0]}};
            end
            default: begin
                lane_we   = 4'b0000;
                wdata_rep = wdata_m;
            end
        endcase
    end

    // Merge new lanes over the current word so untouched lanes keep their value.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_word_d[gi*8 +: 8] = lane_we[gi] ? wdata_rep[gi*8 +: 8]
                                                      : raw_word[gi*8 +: 8];
        end
    endgenerate

    // Array update: reset wipes every word in one cycle and beats any store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (wr_en) begin
            mem_q[idx] <= wr_word_d;
        end
    end

    // Only aligned loads reach the extender; everything else reads as zero.
    assign load_acc = (ld && aligned) ? acc : ACC_NONE;

    dm_load_ext u_load_ext (
        .word_i  (raw_word),
        .off_i   (off),
        .acc_i   (load_acc),
        .rdata_o (rdata_w)
    );

`ifdef DM_WRITE_LOG_EN
    // Trace of committed writes: instruction PC, word address, merged word.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            $display("@%h: *%h <= %h", pc8_m - 32'd8, {addr_m[31:2], 2'b00}, wr_word_d);
        end
    end

    logic unused_ok;
    assign unused_ok = ^instr_m[25:0];
`else
    // Without the trace the PC and the non-opcode/upper-address bits are not needed.
    logic unused_ok;
    assign unused_ok = ^{instr_m[25:0], addr_m[31:IDX_W+2], pc8_m};
`endif

endmodule

// File: tb/tb_m_stage_dm.sv
// Self-checking bench for m_stage_dm: directed scenarios with fixed expected
// values plus randomized traffic checked against a byte-array memory model.
module tb_m_stage_dm;
    import mips_pkg::*;

    localparam int BYTES = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_m;
    logic [31:0] addr_m;
    logic [31:0] wdata_m;
    logic [31:0] pc8_m;
    wire  [31:0] rdata_w;
    wire         align_err;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] mdl [BYTES];

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rst;
        logic [31:0] er;
        logic        ea;
    } step_t;

    m_stage_dm #(.DEPTH_WORDS(1024), .IDX_W(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr_m   (instr_m),
        .addr_m    (addr_m),
        .wdata_m   (wdata_m),
        .pc8_m     (pc8_m),
        .rdata_w   (rdata_w),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    // Present one instruction for a cycle; outputs are valid 1 ns later.
    task automatic issue(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic rst);
        @(negedge clk);
        reset   = rst;
        instr_m = {op, 26'($urandom)};
        addr_m  = addr;
        wdata_m = wd;
        pc8_m   = $urandom;
        #1;
    endtask

    // Reference read: byte-addressed memory, results built arithmetically.
    function automatic void model_read(input logic [5:0] op, input logic [31:0] addr,
                                       output logic [31:0] r, output logic e);
        int a;
        int o;
        logic [15:0] h;
        logic [7:0]  b;
        a = int'(addr % BYTES);
        o = int'(addr % 4);
        r = 32'h0;
        e = 1'b0;
        if (op == OP_LW || op == OP_SW) e = (o != 0);
        if (op == OP_LH || op == OP_LHU || op == OP_SH) e = (o % 2 != 0);
        if (!e) begin
            b = mdl[a];
            if (op == OP_LW)
                r = {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]};
            if (op == OP_LH || op == OP_LHU) begin
                h = {mdl[a+1], mdl[a]};
                r = {16'h0, h};
                if (op == OP_LH && h >= 16'h8000) r = r + 32'hFFFF_0000;
            end
            if (op == OP_LB || op == OP_LBU) begin
                r = {24'h0, b};
                if (op == OP_LB && b >= 8'h80) r = r + 32'hFFFF_FF00;
            end
        end
    endfunction

    // Reference update at the clock edge following issue().
    function automatic void model_commit(input logic [5:0] op, input logic [31:0] addr,
                                         input logic [31:0] wd, input logic rst);
        int a;
        int o;
        a = int'(addr % BYTES);
        o = int'(addr % 4);
        if (rst) begin
            foreach (mdl[i]) mdl[i] = 8'h00;
        end else if (op == OP_SW && o == 0) begin
            mdl[a] = wd[7:0]; mdl[a+1] = wd[15:8]; mdl[a+2] = wd[23:16]; mdl[a+3] = wd[31:24];
        end else if (op == OP_SH && o % 2 == 0) begin
            mdl[a] = wd[7:0]; mdl[a+1] = wd[15:8];
        end else if (op == OP_SB) begin
            mdl[a] = wd[7:0];
        end
    endfunction

    task automatic test_reset();
        step_t steps [4];
        steps = '{
            '{6'h00,  32'h0000_0003, 32'h0,          1'b1, 32'h0, 1'b0},
            '{OP_LW,  32'h0000_0013, 32'h0,          1'b1, 32'h0, 1'b1},
            '{OP_LW,  32'h0000_0010, 32'h0,          1'b0, 32'h0, 1'b0},
            '{6'h0F,  32'h0000_0001, 32'hFFFF_FFFF,  1'b0, 32'h0, 1'b0}
        };
        foreach (steps[i]) begin
            issue(steps[i].op, steps[i].addr, steps[i].wd, steps[i].rst);
            $display("txn reset[%0d] op=%h addr=%h wdata=%h rst=%b -> rdata=%h align=%b",
                     i, steps[i].op, steps[i].addr, steps[i].wd, steps[i].rst, rdata_w, align_err);
            compared++;
            if (rdata_w !== steps[i].er) begin
                mismatched++;
                $display("FAIL reset_rdata[%0d] got %h expected %h", i, rdata_w, steps[i].er);
            end
            compared++;
            if (align_err !== steps[i].ea) begin
                mismatched++;
                $display("FAIL reset_align[%0d] got %b expected %b", i, align_err, steps[i].ea);
            end
            model_commit(steps[i].op, steps[i].addr, steps[i].wd, steps[i].rst);
        end
    endtask

    task automatic test_load_ext();
        step_t steps [8];
        steps = '{
            '{OP_SW,  32'h0000_0020, 32'h8765_4321, 1'b0, 32'h0,          1'b0},
            '{OP_LW,  32'h0000_0020, 32'h0,         1'b0, 32'h8765_4321,  1'b0},
            '{OP_LB,  32'h0000_0023, 32'h0,         1'b0, 32'hFFFF_FF87,  1'b0},
            '{OP_LBU, 32'h0000_0023, 32'h0,         1'b0, 32'h0000_0087,  1'b0},
            '{OP_LH,  32'h0000_0022, 32'h0,         1'b0, 32'hFFFF_8765,  1'b0},
            '{OP_LHU, 32'h0000_0020, 32'h0,         1'b0, 32'h0000_4321,  1'b0},
            '{OP_LH,  32'h0000_0020, 32'h0,         1'b0, 32'h0000_4321,  1'b0},
            '{OP_LB,  32'h0000_0021, 32'h0,         1'b0, 32'h0000_0043,  1'b0}
        };
        foreach (steps[i]) begin
            issue(steps[i].op, steps[i].addr, steps[i].wd, steps[i].rst);
            $display("txn load_ext[%0d] op=%h addr=%h wdata=%h rst=%b -> rdata=%h align=%b",
                     i, steps[i].op, steps[i].addr, steps[i].wd, steps[i].rst, rdata_w, align_err);
            compared++;
            if (rdata_w !== steps[i].er) begin
                mismatched++;
                $display("FAIL load_ext_rdata[%0d] got %h expected %h", i, rdata_w, steps[i].er);
            end
            compared++;
            if (align_err !== steps[i].ea) begin
                mismatched++;
                $display("FAIL load_ext_align[%0d] got %b expected %b", i, align_err, steps[i].ea);
            end
            model_commit(steps[i].op, steps[i].addr, steps[i].wd, steps[i].rst);
        end
    endtask

    task automatic test_lane_merge();
        step_t steps [5];
        steps = '{
            '{OP_SW, 32'h0000_0040, 32'h0000_0000, 1'b0, 32'h0,         1'b0},
            '{OP_SB, 32'h0000_0041, 32'h0000_00AB, 1'b0, 32'h0,         1'b0},
            '{OP_SH, 32'h0000_0042, 32'h0000_CDEF, 1'b0, 32'h0,         1'b0},
            '{OP_LW, 32'h0000_0040, 32'h0,         1'b0, 32'hCDEF_AB00, 1'b0},
            '{OP_LBU,32'h0000_0040, 32'h0,         1'b0, 32'h0000_0000, 1'b0}
        };
        foreach (steps[i]) begin
            issue(steps[i].op, steps[i].addr, steps[i].wd, steps[i].rst);
            $display("txn lane_merge[%0d] op=%h addr=%h wdata=%h rst=%b -> rdata=%h align=%b",
                     i, steps[i].op, steps[i].addr, steps[i].wd, steps[i].rst, rdata_w, align_err);
            compared++;
            if (rdata_w !== steps[i].er) begin
                mismatched++;
                $display("FAIL lane_merge_rdata[%0d] got %h expected %h", i, rdata_w, steps[i].er);
            end
            compared++;
            if (align_err !== steps[i].ea) begin
                mismatched++;
                $display("FAIL lane_merge_align[%0d] got %b expected %b", i, align_err, steps[i].ea);
            end
            model_commit(steps[i].op, steps[i].addr, steps[i].wd, steps[i].rst);
        end
    endtask

    task automatic test_misaligned();
        step_t steps [7];
        steps = '{
            '{OP_SW,  32'h0000_0044, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0},
            '{OP_SW,  32'h0000_0045, 32'h1111_1111, 1'b0, 32'h0,         1'b1},
            '{OP_LH,  32'h0000_0043, 32'h0,         1'b0, 32'h0,         1'b1},
            '{OP_SH,  32'h0000_0047, 32'h2222_2222, 1'b0, 32'h0,         1'b1},
            '{OP_LW,  32'h0000_0046, 32'h0,         1'b0, 32'h0,         1'b1},
            '{OP_LHU, 32'h0000_0045, 32'h0,         1'b0, 32'h0,         1'b1},
            '{OP_LW,  32'h0000_0044, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0}
        };
        foreach (steps[i]) begin
            issue(steps[i].op, steps[i].addr, steps[i].wd, steps[i].rst);
            $display("txn misaligned[%0d] op=%h addr=%h wdata=%h rst=%b -> rdata=%h align=%b",
                     i, steps[i].op, steps[i].addr, steps[i].wd, steps[i].rst, rdata_w, align_err);
            compared++;
            if (rdata_w !== steps[i].er) begin
                mismatched++;
                $display("FAIL misaligned_rdata[%0d] got %h expected %h", i, rdata_w, steps[i].er);
            end
            compared++;
            if (align_err !== steps[i].ea) begin
                mismatched++;
                $display("FAIL misaligned_align[%0d] got %b expected %b", i, align_err, steps[i].ea);
            end
            model_commit(steps[i].op, steps[i].addr, steps[i].wd, steps[i].rst);
        end
    endtask

    task automatic test_wrap_reset();
        step_t steps [6];
        steps = '{
            '{OP_SW, 32'h0000_1000, 32'h1234_5678, 1'b0, 32'h0,         1'b0},
            '{OP_LW, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678, 1'b0},
            '{OP_LW, 32'hFFFF_F000, 32'h0,         1'b0, 32'h1234_5678, 1'b0},
            '{OP_SW, 32'h0000_0000, 32'hAAAA_AAAA, 1'b1, 32'h0,         1'b0},
            '{OP_LW, 32'h0000_0000, 32'h0,         1'b0, 32'h0,         1'b0},
            '{OP_LW, 32'h0000_0020, 32'h0,         1'b0, 32'h0,         1'b0}
        };
        foreach (steps[i]) begin
            issue(steps[i].op, steps[i].addr, steps[i].wd, steps[i].rst);
            $display("txn wrap_reset[%0d] op=%h addr=%h wdata=%h rst=%b -> rdata=%h align=%b",
                     i, steps[i].op, steps[i].addr, steps[i].wd, steps[i].rst, rdata_w, align_err);
            compared++;
            if (rdata_w !== steps[i].er) begin
                mismatched++;
                $display("FAIL wrap_reset_rdata[%0d] got %h expected %h", i, rdata_w, steps[i].er);
            end
            compared++;
            if (align_err !== steps[i].ea) begin
                mismatched++;
                $display("FAIL wrap_reset_align[%0d] got %b expected %b", i, align_err, steps[i].ea);
            end
            model_commit(steps[i].op, steps[i].addr, steps[i].wd, steps[i].rst);
        end
    endtask

    // Store immediately followed by loads of the same word (aliased via upper bits).
    task automatic test_back_to_back();
        logic [31:0] base;
        logic [31:0] data;
        logic [31:0] exp;
        logic [7:0]  b;
        int          o;
        for (int n = 0; n < 16; n++) begin
            base = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 1023)) << 2);
            data = $urandom;
            issue(OP_SW, base, data, 1'b0);
            $display("txn b2b[%0d] SW addr=%h wdata=%h", n, base, data);
            model_commit(OP_SW, base, data, 1'b0);
            issue(OP_LW, base ^ 32'h0001_0000, 32'h0, 1'b0);
            $display("txn b2b[%0d] LW addr=%h -> rdata=%h", n, base ^ 32'h0001_0000, rdata_w);
            compared++;
            if (rdata_w !== data) begin
                mismatched++;
                $display("FAIL b2b_lw[%0d] got %h expected %h", n, rdata_w, data);
            end
            o = $urandom_range(0, 3);
            b = 8'($urandom);
            issue(OP_SB, base + 32'(o), {24'h0, b}, 1'b0);
            $display("txn b2b[%0d] SB addr=%h wdata=%h", n, base + 32'(o), b);
            model_commit(OP_SB, base + 32'(o), {24'h0, b}, 1'b0);
            issue(OP_LBU, base + 32'(o), 32'h0, 1'b0);
            $display("txn b2b[%0d] LBU addr=%h -> rdata=%h", n, base + 32'(o), rdata_w);
            compared++;
            if (rdata_w !== {24'h0, b}) begin
                mismatched++;
                $display("FAIL b2b_lbu[%0d] got %h expected %h", n, rdata_w, {24'h0, b});
            end
            exp = (data & ~(32'hFF << (8 * o))) | ({24'h0, b} << (8 * o));
            issue(OP_LW, base, 32'h0, 1'b0);
            $display("txn b2b[%0d] LW addr=%h -> rdata=%h", n, base, rdata_w);
            compared++;
            if (rdata_w !== exp) begin
                mismatched++;
                $display("FAIL b2b_merge[%0d] got %h expected %h", n, rdata_w, exp);
            end
        end
    endtask

    // Random mix over 16 words with aliasing upper bits and occasional reset.
    task automatic test_random();
        logic [5:0]  ops [10];
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rst;
        logic [31:0] er;
        logic        ea;
        ops = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB, 6'h00, 6'h0F};
        for (int n = 0; n < 300; n++) begin
            op   = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 19) == 0) op = 6'($urandom);
            addr = $urandom & 32'hFFFF_F03F;
            wd   = $urandom;
            rst  = ($urandom_range(0, 63) == 0);
            issue(op, addr, wd, rst);
            model_read(op, addr, er, ea);
            $display("txn random[%0d] op=%h addr=%h wdata=%h rst=%b -> rdata=%h align=%b",
                     n, op, addr, wd, rst, rdata_w, align_err);
            compared++;
            if (rdata_w !== er) begin
                mismatched++;
                $display("FAIL random_rdata[%0d] got %h expected %h", n, rdata_w, er);
            end
            compared++;
            if (align_err !== ea) begin
                mismatched++;
                $display("FAIL random_align[%0d] got %b expected %b", n, align_err, ea);
            end
            model_commit(op, addr, wd, rst);
        end
    endtask

    initial begin
        reset   = 1'b1;
        instr_m = 32'h0;
        addr_m  = 32'h0;
        wdata_m = 32'h0;
        pc8_m   = 32'h0;
        test_reset();
        test_load_ext();
        test_lane_merge();
        test_misaligned();
        test_wrap_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
